// File: rtl/ahb_arb_slave_6_pkg.sv
// AHB_package: AHB transfer/burst encodings and the slave_6 arbiter state,
// plus small helpers shared by the arbiter files.
package AHB_package;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_t;

    localparam int MAX_CHANNELS = 16;

    // Beats still to come after the NONSEQ beat of a burst.
    function automatic logic [3:0] burst_beats(hburst_t b);
        return (b == HB_WRAP4  || b == HB_INCR4)  ? 4'd3  :
               (b == HB_WRAP8  || b == HB_INCR8)  ? 4'd7  :
               (b == HB_WRAP16 || b == HB_INCR16) ? 4'd15 : 4'd0;
    endfunction

    function automatic logic [3:0] onehot_idx(logic [MAX_CHANNELS-1:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAX_CHANNELS; i++)
            idx = idx | (oh[i] ? 4'(i) : 4'd0);
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_slave_6_picker.sv
// ahb_rr_picker: combinational round-robin search starting just after the last owner.
module ahb_rr_picker #(
    parameter int CHANNEL_NUM = 4
) (
    input  logic [CHANNEL_NUM-1:0] i_req,
    input  logic [3:0]             i_last_owner,
    output logic [CHANNEL_NUM-1:0] o_winner
);

    logic w_found;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= CHANNEL_NUM; k++) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (!w_found && i_req[i] && i == (int'(i_last_owner) + k) % CHANNEL_NUM) begin
                    o_winner[i] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_arb_slave_6.sv
// ahb_arb_slave_6: round-robin arbiter for slave_6; tracks the owner's burst so the
// grant only moves on burst boundaries, and holds it for locked sequences.
module ahb_arb_slave_6
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 4
) (
    input  logic                     i_hclk,
    input  logic                     i_hreset_n,
    input  logic [CHANNEL_NUM-1:0]   i_req,
    input  logic [2*CHANNEL_NUM-1:0] i_htrans,
    input  logic [3*CHANNEL_NUM-1:0] i_hburst,
    input  logic [CHANNEL_NUM-1:0]   i_hmastlock,
    input  logic                     i_hready,
    output logic [CHANNEL_NUM-1:0]   o_sel,
    output logic [3:0]               o_hmaster,
    output logic                     o_grant_valid
);

    arb_state_t             r_state, w_state_nx;
    logic [CHANNEL_NUM-1:0] r_sel, w_sel_nx, w_winner;
    logic [3:0]             r_hmaster, w_hmaster_nx;
    logic [3:0]             r_cnt, w_cnt_nx;
    logic [3:0]             r_last, w_last_nx;
    logic                   r_grant_valid;
    logic                   r_unb, w_unb_nx;
    logic                   w_point, w_lock, w_win_lock;
    htrans_t                w_trans;
    hburst_t                w_burst;

    ahb_rr_picker #(
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_picker (
        .i_req        (i_req),
        .i_last_owner (r_last),
        .o_winner     (w_winner)
    );

    // Owner's control signals, selected by the registered one-hot grant.
    always_comb begin
        w_trans = HT_IDLE;
        w_burst = HB_SINGLE;
        w_lock  = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (r_sel[i]) begin
                w_trans = htrans_t'(i_htrans[2*i +: 2]);
                w_burst = hburst_t'(i_hburst[3*i +: 3]);
                w_lock  = i_hmastlock[i];
            end
        end
    end

    // The boundary test looks at the counter after this beat, so the NONSEQ of a
    // multi-beat burst is never itself a re-arbitration point.
    always_comb begin
        w_cnt_nx = r_cnt;
        w_unb_nx = r_unb;
        if (r_state != ST_IDLE) begin
            if (w_trans == HT_NONSEQ) begin
                w_cnt_nx = burst_beats(w_burst);
                w_unb_nx = w_burst == HB_INCR;
            end else if (w_trans == HT_SEQ) begin
                w_cnt_nx = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            end else if (w_trans == HT_IDLE) begin
                w_unb_nx = 1'b0;
            end
        end
        w_point = r_state == ST_IDLE ||
                  (w_cnt_nx == 4'd0 && !w_unb_nx && w_trans != HT_BUSY &&
                   (r_state == ST_OWN || !w_lock));
        w_win_lock   = |(w_winner & i_hmastlock);
        w_state_nx   = r_state;
        w_sel_nx     = r_sel;
        w_hmaster_nx = r_hmaster;
        w_last_nx    = r_last;
        if (w_point) begin
            w_state_nx   = !(|w_winner) ? ST_IDLE : w_win_lock ? ST_LOCK : ST_OWN;
            w_sel_nx     = w_winner;
            w_hmaster_nx = onehot_idx(MAX_CHANNELS'(w_winner));
            w_last_nx    = (|w_winner) ? w_hmaster_nx : r_last;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_hmaster     <= 4'd0;
            r_grant_valid <= 1'b0;
            r_cnt         <= 4'd0;
            r_unb         <= 1'b0;
            r_last        <= 4'(CHANNEL_NUM - 1);
        end else if (i_hready) begin
            r_state       <= w_state_nx;
            r_sel         <= w_sel_nx;
            r_hmaster     <= w_hmaster_nx;
            r_grant_valid <= |w_sel_nx;
            r_cnt         <= w_cnt_nx;
            r_unb         <= w_unb_nx;
            r_last        <= w_last_nx;
        end
    end

    assign o_sel         = r_sel;
    assign o_hmaster     = r_hmaster;
    assign o_grant_valid = r_grant_valid;

endmodule

// File: tb/tb_ahb_arb_slave_6.sv
// tb_ahb_arb_slave_6: directed burst/lock/reset scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_ahb_arb_slave_6;

    localparam int N = 4;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_WRAP16 = 3'd6;

    logic          clk = 1'b0;
    logic          hreset_n;
    logic [N-1:0]  req, hmastlock, sel;
    logic [2*N-1:0] htrans;
    logic [3*N-1:0] hburst;
    logic          hready, gv;
    logic [3:0]    hmaster;
    int            checks = 0;
    int            errors = 0;

    int m_owner, m_left, m_last;
    bit m_unb, m_lock;

    ahb_arb_slave_6 #(.CHANNEL_NUM(N)) dut (
        .i_hclk        (clk),
        .i_hreset_n    (hreset_n),
        .i_req         (req),
        .i_htrans      (htrans),
        .i_hburst      (hburst),
        .i_hmastlock   (hmastlock),
        .i_hready      (hready),
        .o_sel         (sel),
        .o_hmaster     (hmaster),
        .o_grant_valid (gv)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_unb = 0; m_lock = 0; m_last = N - 1;
    endtask

    // Transaction view: beats left in the owner's burst, grant moves only when none remain.
    function automatic void model_edge();
        int t, b, nxt;
        bit rel;
        if (!hready) return;
        rel = 1;
        if (m_owner >= 0) begin
            t = int'(htrans[2*m_owner +: 2]);
            b = int'(hburst[3*m_owner +: 3]);
            if (t == 2) begin
                m_left = (b < 2) ? 0 : (4 << ((b - 2) / 2)) - 1;
                m_unb  = (b == 1);
            end else if (t == 3) m_left = (m_left > 0) ? m_left - 1 : 0;
            else if (t == 0) m_unb = 0;
            rel = m_left == 0 && !m_unb && t != 1 && !(m_lock && hmastlock[m_owner]);
        end
        if (rel) begin
            nxt = -1;
            for (int k = 1; k <= N; k++)
                if (nxt < 0 && req[(m_last + k) % N]) nxt = (m_last + k) % N;
            m_owner = nxt;
            m_lock  = nxt >= 0 && hmastlock[nxt];
            if (nxt >= 0) m_last = nxt;
        end
    endfunction

    function automatic logic [8:0] exp_out();
        return (m_owner < 0) ? 9'd0 : {4'(1 << m_owner), 4'(m_owner), 1'b1};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [1:0] t, input logic [2:0] b, input logic l);
        htrans[2*m +: 2] = t;
        hburst[3*m +: 3] = b;
        hmastlock[m]     = l;
    endtask

    task automatic do_reset();
        hreset_n = 0; req = '0; htrans = '0; hburst = '0; hmastlock = '0; hready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 hreset_n = 1;
    endtask

    task automatic test_reset();
        hreset_n = 0; req = 4'b0101; htrans = '0; hburst = '0; hmastlock = '0; hready = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sel, hmaster, gv} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", {sel, hmaster, gv}, 9'd0);
        end
        hreset_n = 1;
        #1;
        checks++;
        if ({sel, gv} !== 5'd0) begin
            errors++; $display("FAIL no_grant_at_release got=%b exp=%b", {sel, gv}, 5'd0);
        end
        tick();
        checks++;
        if ({sel, hmaster, gv} !== {4'b0001, 4'd0, 1'b1}) begin
            errors++; $display("FAIL first_grant got=%b exp=%b", {sel, hmaster, gv}, {4'b0001, 4'd0, 1'b1});
        end
    endtask

    task automatic test_rr_single();
        do_reset();
        req = 4'b0101;
        tick();
        checks++;
        if (sel !== 4'b0001) begin errors++; $display("FAIL rr_first sel=%b exp=0001", sel); end
        set_m(0, T_NS, B_SINGLE, 0);
        tick();
        checks++;
        if ({sel, hmaster, gv} !== {4'b0100, 4'd2, 1'b1}) begin
            errors++; $display("FAIL rr_after_single got=%b exp=%b", {sel, hmaster, gv}, {4'b0100, 4'd2, 1'b1});
        end
        req = 4'b0000;
        set_m(0, T_IDLE, B_SINGLE, 0);
        tick();
        checks++;
        if ({sel, hmaster, gv} !== 9'd0) begin
            errors++; $display("FAIL rr_to_idle got=%b exp=%b", {sel, hmaster, gv}, 9'd0);
        end
    endtask

    task automatic test_incr4();
        logic [3:0] e;
        do_reset();
        req = 4'b1010;
        tick();
        checks++;
        if (sel !== 4'b0010) begin errors++; $display("FAIL incr4_grant sel=%b exp=0010", sel); end
        set_m(1, T_NS, B_INCR4, 0);
        tick();
        checks++;
        if (sel !== 4'b0010) begin errors++; $display("FAIL incr4_nonseq sel=%b exp=0010", sel); end
        for (int i = 0; i < 3; i++) begin
            set_m(1, T_SEQ, B_INCR4, 0);
            tick();
            e = (i < 2) ? 4'b0010 : 4'b1000;
            checks++;
            if (sel !== e) begin errors++; $display("FAIL incr4_seq%0d sel=%b exp=%b", i, sel, e); end
        end
    endtask

    task automatic test_wait_states();
        logic [3:0] e;
        do_reset();
        req = 4'b0001;
        tick();
        set_m(0, T_NS, B_INCR8, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_m(0, T_SEQ, B_INCR8, 0);
            tick();
        end
        req = 4'b1111;
        hready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({sel, hmaster, gv} !== {4'b0001, 4'd0, 1'b1}) begin
                errors++; $display("FAIL wait_hold%0d got=%b exp=%b", i, {sel, hmaster, gv}, {4'b0001, 4'd0, 1'b1});
            end
        end
        hready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            e = (i < 4) ? 4'b0001 : 4'b0010;
            checks++;
            if (sel !== e) begin errors++; $display("FAIL wait_beat%0d sel=%b exp=%b", i + 4, sel, e); end
        end
    endtask

    task automatic test_lock();
        logic [3:0] e;
        bit last;
        do_reset();
        req = 4'b0100;
        set_m(2, T_IDLE, B_SINGLE, 1);
        tick();
        checks++;
        if (sel !== 4'b0100) begin errors++; $display("FAIL lock_grant sel=%b exp=0100", sel); end
        req = 4'b1111;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                last = (b == 1 && i == 3);
                set_m(2, (i == 0) ? T_NS : T_SEQ, B_INCR4, !last);
                tick();
                e = last ? 4'b1000 : 4'b0100;
                checks++;
                if (sel !== e) begin errors++; $display("FAIL lock_b%0d_beat%0d sel=%b exp=%b", b, i, sel, e); end
            end
        end
    endtask

    task automatic test_busy_and_drop();
        do_reset();
        req = 4'b0011;
        tick();
        set_m(0, T_NS, B_INCR4, 0);
        tick();
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            set_m(0, (i == 2 || i == 3 || i == 4) ? T_BUSY : T_SEQ, B_INCR4, 0);
            tick();
            if (i < 5) begin
                checks++;
                if (sel !== 4'b0001) begin errors++; $display("FAIL busy_hold%0d sel=%b exp=0001", i, sel); end
            end
        end
        checks++;
        if (sel !== 4'b0010) begin errors++; $display("FAIL busy_release sel=%b exp=0010", sel); end
    endtask

    task automatic test_incr_undef();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0011;
        set_m(0, T_NS, B_INCR, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_m(0, T_SEQ, B_INCR, 0);
            tick();
            checks++;
            if (sel !== 4'b0001) begin errors++; $display("FAIL incr_beat%0d sel=%b exp=0001", i, sel); end
        end
        set_m(0, T_IDLE, B_SINGLE, 0);
        tick();
        checks++;
        if (sel !== 4'b0010) begin errors++; $display("FAIL incr_release sel=%b exp=0010", sel); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        tick();
        set_m(0, T_NS, B_WRAP16, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_m(0, T_SEQ, B_WRAP16, 0);
            tick();
        end
        req = 4'b1111;
        #2 hreset_n = 0;
        #1;
        checks++;
        if ({sel, hmaster, gv} !== 9'd0) begin
            errors++; $display("FAIL async_clear got=%b exp=%b", {sel, hmaster, gv}, 9'd0);
        end
        model_reset();
        htrans = '0;
        @(posedge clk);
        #1 hreset_n = 1;
        tick();
        checks++;
        if (sel !== 4'b0001) begin errors++; $display("FAIL async_regrant sel=%b exp=0001", sel); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom);
            for (int m = 0; m < N; m++)
                set_m(m, 2'($urandom), 3'($urandom), $urandom_range(0, 7) == 0);
            hready = $urandom_range(0, 3) != 0;
            tick();
            checks++;
            if ({sel, hmaster, gv} !== exp_out() || !$onehot0(sel)) begin
                errors++; $display("FAIL random_c%0d got=%b exp=%b", c, {sel, hmaster, gv}, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_single();
        test_incr4();
        test_wait_states();
        test_lock();
        test_busy_and_drop();
        test_incr_undef();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
